pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Sequential program-counter and instruction-fetch controller for the lab CPU. It holds the architectural PC and fetches instruction words from instruction memory over a req/ack handshake. Each fetched word is presented to the decoder over a valid/ready handshake. On every accepted instruction it selects the next PC using the 2-bit sequential/branch/jump encoding that the datapath PC multiplexer uses, and it exports that selection on `pc_sel`.

## Interface
- `ADDR_W`, 32, PC and memory address width (word-addressed)
- `RESET_PC`, 32'd0, PC value loaded by reset

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  fetch request; held until `imem_ack`
- `imem_addr`  out  ADDR_W  fetch address; equals `pc`, stable while `imem_req`=1
- `imem_ack`  in  1  memory returns `imem_data` this cycle; ignored when `imem_req`=0
- `imem_data`  in  32  fetched instruction word
- `instr_valid`  out  1  `instr` holds a valid instruction
- `instr`  out  32  registered instruction word
- `instr_ready`  in  1  decoder accepts `instr` this cycle
- `next_sel`  in  2  next-PC request, sampled on accept: 00 sequential, 01 branch-if-zero, 10 jump, 11 reserved
- `branch_target`  in  ADDR_W  target for 01
- `jump_target`  in  ADDR_W  target for 10
- `cond_value`  in  32  branch condition operand; branch taken iff `cond_value`==0
- `pc_sel`  out  2  select actually applied on the last accept (00/01/10)
- `pc`  out  ADDR_W  current PC
- `halted`  out  1  fetch stopped (see Configuration)

## Operation
- States: RESET_IDLE, FETCH, HOLD, HALT.
- RESET_IDLE: entered while `rst_n`=0. Always moves to FETCH on the next cycle.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. When `imem_ack`=1, `instr` is loaded with `imem_data`, `instr_valid` is set, and the state moves to HOLD.
- HOLD: `instr_valid`=1 and `instr` is stable. An accept occurs when `instr_ready`=1. On accept, `pc` and `pc_sel` are updated and the state returns to FETCH with `instr_valid`=0.
- Next-PC rules:
  - 00 → `pc`+1, with wrap-around modulo 2^ADDR_W.
  - 01 → `branch_target` if `cond_value`==0. Otherwise `pc`+1, and `pc_sel` reports 00.
  - 10 → `jump_target`.
  - 11 → treated as 00.
- `instr_ready` outside HOLD has no effect. `imem_ack` outside FETCH has no effect.

## Timing
- Reset values: `pc`=RESET_PC, `pc_sel`=00, `instr`=0, `instr_valid`=0, `imem_req`=0, `halted`=0.
- The first `imem_req` is asserted in the first cycle after `rst_n` rises.
- `imem_ack` may arrive in the first request cycle. `instr_valid` rises the cycle after the ack edge.
- Minimum loop: FETCH(ack) → HOLD(ready) → FETCH, i.e. 2 cycles per instruction. Fetch wait states add 1 cycle each; decoder stalls add 1 cycle each.
- The new `pc` is visible the cycle after accept and is driven on `imem_addr` in that same cycle.
- Reset mid-fetch or mid-hold: all state returns to reset values at that edge. An ack for the abandoned request arriving after reset is ignored. The word in `instr` is discarded.
- `pc` wraps at 2^ADDR_W−1 +1 → 0 with no flag.

## Configuration
- `PCFETCH_HALT_EN` defined:
  - Accepting an instruction equal to 32'hFFFF_FFFF moves the block to HALT instead of FETCH; `pc` is not updated.
  - In HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. The block leaves HALT only via reset.
- `PCFETCH_HALT_EN` undefined:
  - 32'hFFFF_FFFF is an ordinary instruction.
  - HALT is unreachable and `halted` is tied to 0.

## Structure
- Package `pcfetch_pkg`:
  - state encoding
  - select constants SEL_SEQ=2'b00, SEL_BR=2'b01, SEL_JMP=2'b10
  - HALT_WORD=32'hFFFF_FFFF
- Sub-module `next_pc_sel`: purely combinational. Inputs are `pc`, `next_sel`, `branch_target`, `jump_target` and `cond_value`. Outputs are the next PC and the applied select. The top level contains the FSM and the registers.

## Test plan
- Reset, then ack every request in its first cycle, with `instr_ready`=1 and `next_sel`=00 → `imem_addr` sequence 0,1,2,3, one instruction every 2 cycles, `pc_sel`=00.
- At PC 5, `next_sel`=01, `cond_value`=0, `branch_target`=0x40 → next `imem_addr`=0x40, `pc_sel`=01. Repeat with `cond_value`=7 → `imem_addr`=6, `pc_sel`=00.
- At PC 3, `next_sel`=10, `jump_target`=0x100 → `imem_addr`=0x100, `pc_sel`=10. `next_sel`=11 at PC 0x100 → 0x101.
- `imem_ack` delayed 3 cycles and `instr_ready` held low 2 cycles → `imem_addr` and `instr` stay stable throughout; exactly one accept per instruction.
- `RESET_PC`=32'hFFFF_FFFF with `next_sel`=00 → `pc` wraps to 0. Assert `rst_n`=0 during a pending fetch, then a stray ack → `pc`=RESET_PC and no `instr_valid`.
- With `PCFETCH_HALT_EN`: fetch 32'hFFFF_FFFF and accept it → `halted`=1 the next cycle, and `imem_req` stays 0 for 10 cycles. Without the macro, the same word is accepted and the next address is `pc`+1.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC/fetch controller.
// Holds the FSM state encoding, next-PC select codes and the halt word.
package pcfetch_pkg;

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2,
        HALT       = 2'd3
    } state_t;

    localparam logic [1:0]  SEL_SEQ   = 2'b00;
    localparam logic [1:0]  SEL_BR    = 2'b01;
    localparam logic [1:0]  SEL_JMP   = 2'b10;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Combinational next-PC selector for the fetch controller.
// Ports: pc, next_sel, branch_target, jump_target, cond_value in;
//        next_pc (selected PC) and sel_applied (select actually used) out.
module next_pc_sel
    import pcfetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        next_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [31:0]       cond_value,
    output logic [ADDR_W-1:0] next_pc,
    output logic [1:0]        sel_applied
);

    always_comb begin
        // Sequential is the fallback for an untaken branch and the
        // reserved code, so it is also what gets reported for them.
        next_pc     = pc + ADDR_W'(1);
        sel_applied = SEL_SEQ;
        unique case (next_sel)
            SEL_BR: begin
                if (cond_value == 32'd0) begin
                    next_pc     = branch_target;
                    sel_applied = SEL_BR;
                end
            end
            SEL_JMP: begin
                next_pc     = jump_target;
                sel_applied = SEL_JMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch controller (req/ack to imem,
// valid/ready to decoder). Optional halt-on-0xFFFFFFFF: PCFETCH_HALT_EN.
// Ports: clk, rst_n (sync, active-low); imem_req/addr/ack/data;
// instr_valid/instr/instr_ready; next_sel, branch_target, jump_target,
// cond_value; pc_sel, pc, halted.
module pc_fetch_ctrl
    import pcfetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              instr_valid,
    output logic [31:0]       instr,
    input  logic              instr_ready,
    input  logic [1:0]        next_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [31:0]       cond_value,
    output logic [1:0]        pc_sel,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        pc_sel_q, pc_sel_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] npc;
    logic [1:0]        npc_sel;
`ifdef PCFETCH_HALT_EN
    logic              halted_q, halted_d;
`endif

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc            (pc_q),
        .next_sel      (next_sel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .cond_value    (cond_value),
        .next_pc       (npc),
        .sel_applied   (npc_sel)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_sel_d = pc_sel_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        req_d    = req_q;
`ifdef PCFETCH_HALT_EN
        halted_d = halted_q;
`endif
        unique case (state_q)
            RESET_IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
`ifdef PCFETCH_HALT_EN
                    if (instr_q == HALT_WORD) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d     = npc;
                        pc_sel_d = npc_sel;
                        req_d    = 1'b1;
                        state_d  = FETCH;
                    end
`else
                    pc_d     = npc;
                    pc_sel_d = npc_sel;
                    req_d    = 1'b1;
                    state_d  = FETCH;
`endif
                end
            end
            HALT: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RESET_IDLE;
            pc_q     <= RESET_PC;
            pc_sel_q <= SEL_SEQ;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
`ifdef PCFETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_sel_q <= pc_sel_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
`ifdef PCFETCH_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_sel      = pc_sel_q;
    assign pc          = pc_q;
`ifdef PCFETCH_HALT_EN
    assign halted      = halted_q;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl (default RESET_PC and an all-ones
// RESET_PC instance sharing inputs). Honours PCFETCH_HALT_EN.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_ready;
    logic [1:0]  next_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] cond_value;

    logic        req0, valid0, halted0;
    logic [31:0] addr0, instr0, pc0;
    logic [1:0]  sel0;
    logic        req1, valid1, halted1;
    logic [31:0] addr1, instr1, pc1;
    logic [1:0]  sel1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'd0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(valid0), .instr(instr0), .instr_ready(instr_ready),
        .next_sel(next_sel), .branch_target(branch_target),
        .jump_target(jump_target), .cond_value(cond_value),
        .pc_sel(sel0), .pc(pc0), .halted(halted0)
    );

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF)) u1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(valid1), .instr(instr1), .instr_ready(instr_ready),
        .next_sel(next_sel), .branch_target(branch_target),
        .jump_target(jump_target), .cond_value(cond_value),
        .pc_sel(sel1), .pc(pc1), .halted(halted1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH: ack in first cycle, accept in first
    // HOLD cycle, then check the address fetched next.
    task automatic do_instr(input string tag, input logic [31:0] data,
                            input logic [1:0] sel, input logic [31:0] br,
                            input logic [31:0] jt, input logic [31:0] cv,
                            input logic [31:0] exp_addr,
                            input logic [1:0] exp_sel);
        chk({tag, "_req"}, 32'(req0), 32'd1);
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack = 1'b0;
        chk({tag, "_valid"}, 32'(valid0), 32'd1);
        chk({tag, "_instr"}, instr0, data);
        next_sel      = sel;
        branch_target = br;
        jump_target   = jt;
        cond_value    = cv;
        instr_ready   = 1'b1;
        step();
        instr_ready = 1'b0;
        chk({tag, "_addr"}, addr0, exp_addr);
        chk({tag, "_sel"}, 32'(sel0), 32'(exp_sel));
        chk({tag, "_vld0"}, 32'(valid0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_data = '0;
        instr_ready = 1'b0;
        next_sel = 2'b00;
        branch_target = '0;
        jump_target = '0;
        cond_value = '0;
        step(); step(); step();

        chk("rst_pc", pc0, 32'd0);
        chk("rst_sel", 32'(sel0), 32'd0);
        chk("rst_instr", instr0, 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_halted", 32'(halted0), 32'd0);
        chk("rst1_pc", pc1, 32'hFFFF_FFFF);
        chk("rst1_misc", {instr1[29:0], valid1, req1 | halted1 | |sel1},
            32'd0);

        rst_n = 1'b1;
        step();
        chk("first_req", 32'(req0), 32'd1);
        chk("first_addr", addr0, 32'd0);
        chk("first_addr1", addr1, 32'hFFFF_FFFF);

        do_instr("seq0", 32'h1111_0000, 2'b00, 0, 0, 0, 32'd1, 2'b00);
        chk("wrap_pc1", pc1, 32'd0);
        chk("wrap_addr1", addr1, 32'd0);
        chk("wrap_sel1", 32'(sel1), 32'd0);
        do_instr("seq1", 32'h1111_0001, 2'b00, 0, 0, 0, 32'd2, 2'b00);
        do_instr("seq2", 32'h1111_0002, 2'b00, 0, 0, 0, 32'd3, 2'b00);

        do_instr("jmp", 32'h2222_0000, 2'b10, 32'h55, 32'h100, 32'h9,
                 32'h100, 2'b10);
        do_instr("rsv", 32'h2222_0001, 2'b11, 32'h55, 32'h77, 32'h0,
                 32'h101, 2'b00);

        do_instr("to5a", 32'h3333_0000, 2'b10, 0, 32'd5, 0, 32'd5, 2'b10);
        do_instr("br_tk", 32'h3333_0001, 2'b01, 32'h40, 32'h99, 32'd0,
                 32'h40, 2'b01);
        do_instr("to5b", 32'h3333_0002, 2'b10, 0, 32'd5, 0, 32'd5, 2'b10);
        do_instr("br_nt", 32'h3333_0003, 2'b01, 32'h40, 32'h99, 32'd7,
                 32'd6, 2'b00);

        // Fetch wait states, with a stray decoder ready that must be ignored
        next_sel    = 2'b00;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", addr0, 32'd6);
            chk("wait_req", 32'(req0), 32'd1);
            chk("wait_valid", 32'(valid0), 32'd0);
        end
        instr_ready = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 32'hABCD_0006;
        step();
        imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_instr", instr0, 32'hABCD_0006);
            chk("stall_valid", 32'(valid0), 32'd1);
            chk("stall_addr", addr0, 32'd6);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("stall_acc", addr0, 32'd7);
        step();
        chk("one_accept", pc0, 32'd7);
        chk("one_req", 32'(req0), 32'd1);
        instr_ready = 1'b0;

        // Reset during a pending fetch, then a stray ack
        rst_n = 1'b0;
        step();
        chk("rf_pc", pc0, 32'd0);
        chk("rf_req", 32'(req0), 32'd0);
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'h5A5A_5A5A;
        step();
        imem_ack = 1'b0;
        chk("rf_valid", 32'(valid0), 32'd0);
        chk("rf_instr", instr0, 32'd0);
        chk("rf_req2", 32'(req0), 32'd1);
        step();
        chk("rf_valid2", 32'(valid0), 32'd0);

        // Reset while holding an instruction
        imem_ack  = 1'b1;
        imem_data = 32'h7777_7777;
        step();
        imem_ack = 1'b0;
        chk("rh_pre", 32'(valid0), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rh_valid", 32'(valid0), 32'd0);
        chk("rh_instr", instr0, 32'd0);
        rst_n = 1'b1;
        step();

        // All-ones instruction
        imem_ack  = 1'b1;
        imem_data = 32'hFFFF_FFFF;
        step();
        imem_ack = 1'b0;
        chk("hw_instr", instr0, 32'hFFFF_FFFF);
        next_sel    = 2'b00;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
`ifdef PCFETCH_HALT_EN
        chk("halt_flag", 32'(halted0), 32'd1);
        chk("halt_pc", pc0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            imem_ack    = 1'(i & 1);
            instr_ready = 1'b1;
            step();
            chk("halt_req", 32'(req0), 32'd0);
            chk("halt_valid", 32'(valid0), 32'd0);
            chk("halt_stay", 32'(halted0), 32'd1);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
`else
        chk("nohalt_addr", addr0, 32'd1);
        chk("nohalt_req", 32'(req0), 32'd1);
        chk("nohalt_flag", 32'(halted0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
